// File: rtl/fre_mul_datapath.sv
// Frequency-multiplier datapath: measures one sig_in period, then counts it down in 2^LOG2_MULT slices.
// Build option: define FMUL_OUT_TOGGLE_EN for a square-wave f_out; otherwise f_out pulses.
module fre_mul_datapath #(
  parameter int unsigned W         = 8,
  parameter int unsigned LOG2_MULT = 2,
  parameter int unsigned PULSES    = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  input  logic         init1,
  input  logic         up,
  input  logic         init2,
  input  logic         down,
  output logic         cnt_complete,
  output logic         equal,
  output logic         end_cal,
  output logic [W-1:0] period,
  output logic         ovf,
  output logic         f_out
);

  localparam int unsigned PW = $clog2(PULSES + 1);
  localparam logic [W-1:0] CntMax = '1;

  logic [2:0]    sync_q;
  logic          rise;
  logic [W-1:0]  cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  period_q, period_d;
  logic [W-1:0]  shifted, reload;
  logic [W-1:0]  dcnt_q, dcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          loaded_q, loaded_d;
  logic          fout_q, fout_d;

  // sync_q[1:0] is the 2-flop synchronizer, sync_q[2] the edge-detect history.
  assign rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    ovf_d    = ovf_q;
    period_d = period_q;
    if (init1) begin
      cnt_d   = '0;
      armed_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (up) begin
      if (!armed_q && rise) begin
        armed_d = 1'b1;
        cnt_d   = W'(1);
      end else if (armed_q && !rise) begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntMax - 1'b1) ovf_d = 1'b1;
        end
      end else if (armed_q && rise) begin
        period_d = cnt_q;
        armed_d  = 1'b0;
      end
    end
  end

  assign shifted = period_q >> LOG2_MULT;
  assign reload  = (shifted == '0) ? W'(1) : shifted;

  // loaded_q keeps equal quiet after reset until the first reload has happened.
  always_comb begin
    dcnt_d   = dcnt_q;
    pcnt_d   = pcnt_q;
    loaded_d = loaded_q;
    if (init2) begin
      dcnt_d   = reload - 1'b1;
      loaded_d = 1'b1;
      pcnt_d   = down ? pcnt_q + 1'b1 : '0;
    end else if (down && dcnt_q != '0) begin
      dcnt_d = dcnt_q - 1'b1;
    end
  end

  assign cnt_complete = up & armed_q & rise;
  assign equal        = down & loaded_q & (dcnt_q == '0);
  assign end_cal      = equal & (pcnt_q == PW'(PULSES - 1));

  always_comb begin
`ifdef FMUL_OUT_TOGGLE_EN
    fout_d = fout_q;
    if (init2 && !down) begin
      fout_d = 1'b0;
    end else if (equal) begin
      fout_d = ~fout_q;
    end
`else
    fout_d = equal;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      ovf_q    <= 1'b0;
      period_q <= '0;
      dcnt_q   <= '0;
      pcnt_q   <= '0;
      loaded_q <= 1'b0;
      fout_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], sig_in};
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      ovf_q    <= ovf_d;
      period_q <= period_d;
      dcnt_q   <= dcnt_d;
      pcnt_q   <= pcnt_d;
      loaded_q <= loaded_d;
      fout_q   <= fout_d;
    end
  end

  assign period = period_q;
  assign ovf    = ovf_q;
  assign f_out  = fout_q;

endmodule

// File: doc/fre_mul_datapath.md
# fre_mul_datapath

Datapath partner of the frequency-multiplier controller. It executes the controller's `init1`/`up`/`init2`/`down` commands and returns `cnt_complete`/`equal`/`end_cal`. It measures one period of an asynchronous input `sig_in` in `clk` cycles, divides that period by 2^LOG2_MULT, and counts the result down repeatedly to emit `PULSES` evenly spaced output events.

## Interface
- `W`, 8: width of measurement, period and down counters.
- `LOG2_MULT`, 2: multiplication factor exponent (factor = 2^LOG2_MULT).
- `PULSES`, 16: output events per calculation, ≥1.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `sig_in`  in  1  asynchronous input whose frequency is multiplied.
- `init1`  in  1  clear measurement state.
- `up`  in  1  measurement enable.
- `init2`  in  1  load or reload down counter.
- `down`  in  1  countdown enable.
- `cnt_complete`  out  1  second rising edge seen during `up`.
- `equal`  out  1  down counter at zero during `down`.
- `end_cal`  out  1  last output event of the calculation.
- `period`  out  W  latched measured period.
- `ovf`  out  1  measurement saturated.
- `f_out`  out  1  multiplied output; see Configuration.

## Operation
- Input conditioning: 2-flop synchronizer on `sig_in`, then a third flop for edge detection. `rise` = s2 & ~s3. A `sig_in` edge becomes visible 2–3 clk later.
- Measurement counter `C` (W bits) and flag `armed`:
  - `init1`: C=0, armed=0, ovf=0.
  - `up` & `rise` & ~armed: armed=1, C=1.
  - `up` & armed & ~`rise`: C=C+1. Saturates at 2^W−1; reaching saturation sets `ovf`=1.
  - `up` & armed & `rise`: `period`<=C, armed=0.
- `cnt_complete` = up & armed & rise. Combinational from flops; high for exactly one cycle.
- Reload value L = period >> LOG2_MULT, forced to 1 if the shift yields 0.
- Down counter `D` (W bits) and pulse counter `P` (ceil(log2(PULSES+1)) bits):
  - `init2` & ~`down`: D=L−1, P=0 (initial load).
  - `init2` & `down`: D=L−1, P=P+1 (reload after an event). `init2` has priority over decrement.
  - `down` & ~`init2`: D=D−1 if D>0, else hold.
- `equal` = down & (D==0). Combinational.
- `end_cal` = equal & (P==PULSES−1). Combinational.
- Net effect: one `equal` every L cycles, and `end_cal` coincides with the PULSES-th `equal`.
- Commands outside these cases leave all state unchanged. `period` holds until the next second edge.

## Timing
- Reset (`rst`=0): C, D, P, armed, `period`, `ovf`, `f_out`, and synchronizer flops are 0. All outputs are 0 during reset and on the first cycle after release.
- Measurement latency: `period` valid on the clk edge after `cnt_complete`. The controller's following `init2` cycle sees the new value.
- Period resolution: ±1 clk due to synchronizer phase.
- First `equal` appears L cycles after the first `down` cycle. Subsequent events are spaced exactly L cycles.
- Simultaneous `init1` & `up`: `init1` wins.
- `rise` arriving on the saturation cycle: `period`=2^W−1, `ovf`=1.
- Reset asserted mid-operation clears everything immediately. No partial `period` is kept.

## Configuration
- `FMUL_OUT_TOGGLE_EN` defined: `f_out` is a register that toggles on every `equal`, producing a square wave of period 2L cycles. It is cleared on initial `init2`.
- `FMUL_OUT_TOGGLE_EN` undefined: `f_out` is a register equal to `equal` delayed by one cycle, producing one-cycle pulses spaced L cycles.

## Test plan
- Defaults (W=8, LOG2_MULT=2, PULSES=16); `sig_in` period 40 clk; controller sequence `init1`, `up` -> `cnt_complete` one cycle, `period`=40±1, L=10, `equal` every 10 cycles, `end_cal` on 16th `equal`.
- `sig_in` period 3 clk -> `period`=3, L forced to 1, `equal` high every `down` cycle, `end_cal` on 16th cycle of countdown.
- `sig_in` period 400 clk -> C saturates, `ovf`=1, `period`=255, L=63.
- `init2` & `down` together with D=5 -> D=L−1 and P increments; no decrement that cycle.
- `rst` low during countdown (P=7) -> all outputs 0 asynchronously; after release, `equal`/`end_cal` stay 0 until a new `init2`.
- With `FMUL_OUT_TOGGLE_EN`, L=10 -> `f_out` toggles every 10 cycles. Without it -> `f_out` one-cycle pulse, one clk after each `equal`.
